cam_capture_ctrl: RTL and testbench

- Parametrised successor of the camera write path in the memory controller.
- Assembles 8-bit camera bytes into frame-buffer pixel words and generates linear write addresses.
- Adds a configurable frame size, RGB444/RGB565 input formats, 2:1 decimation, single-shot/continuous capture, line/frame error detection and a frame counter.
- Sits between the camera input synchroniser and the full_buffer write port, all on sys_clk.

---
 rtl/cam_capture_ctrl_pkg.sv | 23 ++
 rtl/cam_pix_pack.sv | 27 ++
 rtl/cam_capture_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_capture_ctrl_pkg.sv
// Shared types and constants for the camera capture path.
package cam_capture_ctrl_pkg;

    // Default camera geometry (VGA).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;

    // Input byte formats selected by the fmt pin.
    localparam logic FMT_RGB444 = 1'b0;
    localparam logic FMT_RGB565 = 1'b1;

    // Capture FSM states; the encoding is visible on state_dbg.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_VS   = 3'd1,
        ST_WAIT_HREF = 3'd2,
        ST_BYTE1     = 3'd3,
        ST_BYTE0     = 3'd4,
        ST_LINE_END  = 3'd5,
        ST_DONE      = 3'd6
    } cap_state_t;

endpackage

// File: rtl/cam_pix_pack.sv
// Combinational packer: two camera bytes plus format -> RGB444 pixel word.
module cam_pix_pack
    import cam_capture_ctrl_pkg::*;
#(
    parameter int DWIDTH = 12
) (
    input  logic [7:0]        byte0,
    input  logic [7:0]        byte1,
    input  logic              fmt,
    output logic [DWIDTH-1:0] pix
);

    logic [11:0] rgb444;

    // RGB565 keeps the top four bits of each colour channel; RGB444 is taken as-is.
    always_comb begin
        rgb444 = {byte0[3:0], byte1};
        case (fmt)
            FMT_RGB444: rgb444 = {byte0[3:0], byte1};
            FMT_RGB565: rgb444 = {byte0[7:4], byte0[2:0], byte1[7], byte1[4:1]};
            default:    rgb444 = {byte0[3:0], byte1};
        endcase
    end

    assign pix = DWIDTH'(rgb444);

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera write path: assembles byte pairs into pixels, generates linear
// frame-buffer addresses, detects line/frame errors and counts frames.
//
// Handshake: byte_en is a valid-only strobe. din and href are consumed in
// the cycle byte_en is high; there is no ready, the block always accepts.
// wen is likewise a valid-only write strobe qualifying waddr/wdata for one
// cycle; the frame buffer must accept every write.
module cam_capture_ctrl
    import cam_capture_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int DWIDTH   = 12,
    parameter int AWIDTH   = 19,
    parameter int FCNT_W   = 8
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              byte_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        din,
    input  logic              fmt,
    input  logic              decim_en,
    input  logic              arm,
    input  logic              cont,
    output logic              wen,
    output logic [AWIDTH-1:0] waddr,
    output logic [DWIDTH-1:0] wdata,
    output logic              frame_start,
    output logic              frame_done,
    output logic              err_line,
    output logic              err_frame,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [2:0]        state_dbg
);

    localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_ACTIVE - 1);
    localparam logic [ROW_W-1:0]  ROW_END   = ROW_W'(V_ACTIVE);
    localparam logic [AWIDTH-1:0] STEP_FULL = AWIDTH'(H_ACTIVE);
    localparam logic [AWIDTH-1:0] STEP_HALF = AWIDTH'(H_ACTIVE / 2);

    cap_state_t        state, state_n;
    logic              vs_q, vs_rise, vs_fall;
    logic [ROW_W-1:0]  row, row_n;
    logic [COL_W-1:0]  col, col_n;
    logic [AWIDTH-1:0] line_base, line_base_n, base_step, col_addr;
    logic              fmt_q, fmt_n, decim_q, decim_n;
    logic              long_seen, long_seen_n;
    logic [7:0]        byte0_q, byte0_n;
    logic [DWIDTH-1:0] pix;
    logic              wen_n;
    logic [AWIDTH-1:0] waddr_n;
    logic [DWIDTH-1:0] wdata_n;
    logic              frame_start_n, frame_done_n, err_line_n, err_frame_n;
    logic [FCNT_W-1:0] frame_cnt_n;

    assign vs_rise   = vsync & ~vs_q;
    assign vs_fall   = ~vsync & vs_q;
    assign state_dbg = state;

    // When decimating only even rows consume buffer space, so odd rows leave the base alone.
    assign base_step = decim_q ? (row[0] ? '0 : STEP_HALF) : STEP_FULL;
    assign col_addr  = decim_q ? AWIDTH'(col >> 1) : AWIDTH'(col);

    cam_pix_pack #(.DWIDTH(DWIDTH)) u_pix_pack (
        .byte0 (byte0_q),
        .byte1 (din),
        .fmt   (fmt_q),
        .pix   (pix)
    );

    // Next-state, counter and registered-output computation for the capture FSM.
    always_comb begin
        state_n       = state;
        row_n         = row;
        col_n         = col;
        line_base_n   = line_base;
        fmt_n         = fmt_q;
        decim_n       = decim_q;
        byte0_n       = byte0_q;
        long_seen_n   = long_seen;
        wen_n         = 1'b0;
        waddr_n       = waddr;
        wdata_n       = wdata;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        err_line_n    = 1'b0;
        err_frame_n   = 1'b0;
        frame_cnt_n   = frame_cnt;

        case (state)
            ST_IDLE: begin
                if (arm) state_n = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (vs_fall) begin
                    fmt_n         = fmt;
                    decim_n       = decim_en;
                    row_n         = '0;
                    col_n         = '0;
                    line_base_n   = '0;
                    long_seen_n   = 1'b0;
                    frame_start_n = 1'b1;
                    state_n       = ST_WAIT_HREF;
                end
            end
            ST_WAIT_HREF, ST_BYTE0: begin
                if (vs_rise) begin
                    err_frame_n = 1'b1;
                    state_n     = ST_WAIT_VS;
                end else if (state == ST_WAIT_HREF && row == ROW_END) begin
                    state_n = ST_DONE;
                end else if (byte_en) begin
                    if (href) begin
                        byte0_n = din;
                        state_n = ST_BYTE1;
                    end else if (state == ST_BYTE0) begin
                        err_line_n  = 1'b1;
                        row_n       = row + 1'b1;
                        col_n       = '0;
                        line_base_n = line_base + base_step;
                        state_n     = ST_WAIT_HREF;
                    end
                end
            end
            ST_BYTE1: begin
                if (vs_rise) begin
                    err_frame_n = 1'b1;
                    state_n     = ST_WAIT_VS;
                end else if (byte_en) begin
                    if (href) begin
                        wen_n   = ~decim_q | (~col[0] & ~row[0]);
                        waddr_n = line_base + col_addr;
                        wdata_n = pix;
                        if (col < COL_LAST) begin
                            col_n   = col + 1'b1;
                            state_n = ST_BYTE0;
                        end else begin
                            row_n       = row + 1'b1;
                            col_n       = '0;
                            line_base_n = line_base + base_step;
                            long_seen_n = 1'b0;
                            // The last line finishes straight away so frame_done follows the final write.
                            state_n     = (row == ROW_LAST) ? ST_DONE : ST_LINE_END;
                        end
                    end else begin
                        err_line_n  = 1'b1;
                        row_n       = row + 1'b1;
                        col_n       = '0;
                        line_base_n = line_base + base_step;
                        state_n     = ST_WAIT_HREF;
                    end
                end
            end
            ST_LINE_END: begin
                if (vs_rise) begin
                    err_frame_n = 1'b1;
                    state_n     = ST_WAIT_VS;
                end else if (byte_en) begin
                    if (href) begin
                        err_line_n  = ~long_seen;
                        long_seen_n = 1'b1;
                    end else begin
                        state_n = ST_WAIT_HREF;
                    end
                end
            end
            ST_DONE: begin
                frame_done_n = 1'b1;
                frame_cnt_n  = frame_cnt + 1'b1;
                state_n      = cont ? ST_WAIT_VS : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State, counters and all outputs are registered; reset clears everything.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            vs_q        <= 1'b0;
            row         <= '0;
            col         <= '0;
            line_base   <= '0;
            fmt_q       <= 1'b0;
            decim_q     <= 1'b0;
            long_seen   <= 1'b0;
            byte0_q     <= '0;
            wen         <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            vs_q        <= vsync;
            row         <= row_n;
            col         <= col_n;
            line_base   <= line_base_n;
            fmt_q       <= fmt_n;
            decim_q     <= decim_n;
            long_seen   <= long_seen_n;
            byte0_q     <= byte0_n;
            wen         <= wen_n;
            waddr       <= waddr_n;
            wdata       <= wdata_n;
            frame_start <= frame_start_n;
            frame_done  <= frame_done_n;
            err_line    <= err_line_n;
            err_frame   <= err_frame_n;
            busy        <= (state_n != ST_IDLE);
            frame_cnt   <= frame_cnt_n;
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl on an 8x4 frame.
module tb_cam_capture_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 5;
    localparam int DW = 12;
    localparam int FW = 8;

    logic          sys_clk  = 1'b0;
    logic          rst      = 1'b0;
    logic          byte_en  = 1'b0;
    logic          vsync    = 1'b0;
    logic          href     = 1'b0;
    logic [7:0]    din      = 8'h00;
    logic          fmt      = 1'b0;
    logic          decim_en = 1'b0;
    logic          arm      = 1'b0;
    logic          cont     = 1'b0;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          frame_start, frame_done, err_line, err_frame, busy;
    logic [FW-1:0] frame_cnt;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: expected and observed writes packed as {addr, data}.
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int rd_idx = 0;

    int fs_cnt = 0, fd_cnt = 0, el_cnt = 0, ef_cnt = 0;
    int cyc = 0, last_wen_cyc = 0, fd_gap = 0;
    int fs0, fd0, el0, ef0;

    // ---------------- clock / reset block ----------------
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    cam_capture_ctrl #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .DWIDTH   (DW),
        .AWIDTH   (AW),
        .FCNT_W   (FW)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .byte_en     (byte_en),
        .vsync       (vsync),
        .href        (href),
        .din         (din),
        .fmt         (fmt),
        .decim_en    (decim_en),
        .arm         (arm),
        .cont        (cont),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .err_line    (err_line),
        .err_frame   (err_frame),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .state_dbg   (state_dbg)
    );

    function automatic logic [31:0] mk(input int a, input int d);
        return (32'(a) << 16) | (32'(d) & 32'h0000_FFFF);
    endfunction

    // Pattern pixel: byte0 = 0x50|col, byte1 = {row,col}; RGB444 word = {col,row,col}.
    function automatic int pat_word(input int r, input int c);
        return (c << 8) | (r << 4) | c;
    endfunction

    // ---------------- output monitor (negedge sampling) ----------------
    always @(negedge sys_clk) begin
        cyc = cyc + 1;
        if (wen) begin
            got_q.push_back(mk(int'(waddr), int'(wdata)));
            last_wen_cyc = cyc;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_gap = cyc - last_wen_cyc;
        end
        if (frame_start) fs_cnt = fs_cnt + 1;
        if (err_line)    el_cnt = el_cnt + 1;
        if (err_frame)   ef_cnt = ef_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare_writes(input string tag);
        int n_got, n_exp;
        n_got = got_q.size() - rd_idx;
        n_exp = exp_q.size();
        check({tag, "_nwrites"}, 32'(n_got), 32'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (rd_idx + i < got_q.size())
                check($sformatf("%s_wr%0d", tag, i), got_q[rd_idx + i], exp_q[i]);
        end
        rd_idx = got_q.size();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"},       32'(wen),         32'd0);
        check({tag, "_waddr"},     32'(waddr),       32'd0);
        check({tag, "_wdata"},     32'(wdata),       32'd0);
        check({tag, "_fstart"},    32'(frame_start), 32'd0);
        check({tag, "_fdone"},     32'(frame_done),  32'd0);
        check({tag, "_errline"},   32'(err_line),    32'd0);
        check({tag, "_errframe"},  32'(err_frame),   32'd0);
        check({tag, "_busy"},      32'(busy),        32'd0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt),   32'd0);
        check({tag, "_state"},     32'(state_dbg),   32'd0);
    endtask

    task automatic snap();
        fs0 = fs_cnt; fd0 = fd_cnt; el0 = el_cnt; ef0 = ef_cnt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic h);
        byte_en = 1'b1; href = h; din = b;
        tick();
        byte_en = 1'b0; href = 1'b0;
        tick();
    endtask

    task automatic send_pix(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) send_byte(8'h00, 1'b0);
    endtask

    task automatic pat_line(input int r, input int npix);
        logic [7:0] b0, b1;
        for (int c = 0; c < npix; c++) begin
            b0 = 8'h50 | 8'(c);
            b1 = 8'((r << 4) | c);
            send_pix(b0, b1);
        end
    endtask

    task automatic const_line(input logic [7:0] b0, input logic [7:0] b1);
        for (int c = 0; c < H; c++) send_pix(b0, b1);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (2) tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && busy; i++) tick();
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    endtask

    task automatic push_full_pat();
        for (int r = 0; r < V; r++)
            for (int c = 0; c < H; c++)
                exp_q.push_back(mk(r * H + c, pat_word(r, c)));
    endtask

    task automatic pat_frame();
        for (int r = 0; r < V; r++) begin
            pat_line(r, H);
            blank(2);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        rst = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // A: single-shot RGB444 frame, linear addresses 0..31.
        snap();
        fmt = 1'b0; decim_en = 1'b0; cont = 1'b0;
        arm_pulse();
        check("a_busy_armed", 32'(busy), 32'd1);
        push_full_pat();
        start_frame();
        pat_frame();
        wait_idle("a");
        compare_writes("a");
        check("a_fstart", 32'(fs_cnt - fs0), 32'd1);
        check("a_fdone",  32'(fd_cnt - fd0), 32'd1);
        check("a_fd_gap", 32'(fd_gap),       32'd1);
        check("a_errline", 32'(el_cnt - el0), 32'd0);
        check("a_errframe", 32'(ef_cnt - ef0), 32'd0);
        check("a_frame_cnt", 32'(frame_cnt), 32'd1);

        // B1: RGB444 packing, AB CD -> BCD.
        arm_pulse();
        for (int i = 0; i < H * V; i++) exp_q.push_back(mk(i, 12'hBCD));
        start_frame();
        for (int r = 0; r < V; r++) begin
            const_line(8'hAB, 8'hCD);
            blank(2);
        end
        wait_idle("b444");
        compare_writes("b444");
        check("b444_frame_cnt", 32'(frame_cnt), 32'd2);

        // B2: RGB565 packing, F8 1F -> F0F.
        fmt = 1'b1;
        arm_pulse();
        for (int i = 0; i < H * V; i++) exp_q.push_back(mk(i, 12'hF0F));
        start_frame();
        for (int r = 0; r < V; r++) begin
            const_line(8'hF8, 8'h1F);
            blank(2);
        end
        wait_idle("b565");
        compare_writes("b565");
        check("b565_frame_cnt", 32'(frame_cnt), 32'd3);

        // C: 2:1 decimation keeps (even col, even row) at addresses 0..7.
        snap();
        fmt = 1'b0; decim_en = 1'b1;
        arm_pulse();
        for (int r = 0; r < V; r += 2)
            for (int c = 0; c < H; c += 2)
                exp_q.push_back(mk((r / 2) * (H / 2) + c / 2, pat_word(r, c)));
        start_frame();
        pat_frame();
        wait_idle("dec");
        compare_writes("dec");
        check("dec_fdone", 32'(fd_cnt - fd0), 32'd1);
        check("dec_frame_cnt", 32'(frame_cnt), 32'd4);

        // D: line 1 short by 2 pixels, line 2 long by 3 bytes.
        snap();
        decim_en = 1'b0;
        arm_pulse();
        for (int c = 0; c < H; c++)     exp_q.push_back(mk(c, pat_word(0, c)));
        for (int c = 0; c < H - 2; c++) exp_q.push_back(mk(8 + c, pat_word(1, c)));
        for (int c = 0; c < H; c++)     exp_q.push_back(mk(16 + c, pat_word(2, c)));
        for (int c = 0; c < H; c++)     exp_q.push_back(mk(24 + c, pat_word(3, c)));
        start_frame();
        pat_line(0, H);     blank(2);
        pat_line(1, H - 2); blank(2);
        check("d_short_errline", 32'(el_cnt - el0), 32'd1);
        pat_line(2, H);
        for (int i = 0; i < 3; i++) send_byte(8'hEE, 1'b1);
        blank(2);
        check("d_long_errline", 32'(el_cnt - el0), 32'd2);
        pat_line(3, H);     blank(2);
        wait_idle("d");
        compare_writes("d");
        check("d_errframe", 32'(ef_cnt - ef0), 32'd0);
        check("d_fdone", 32'(fd_cnt - fd0), 32'd1);
        check("d_frame_cnt", 32'(frame_cnt), 32'd5);

        // E: continuous mode, vsync aborts after 2 rows, next frame restarts at 0.
        snap();
        cont = 1'b1;
        arm_pulse();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < H; c++)
                exp_q.push_back(mk(r * H + c, pat_word(r, c)));
        push_full_pat();
        start_frame();
        pat_line(0, H); blank(2);
        pat_line(1, H); blank(2);
        vsync = 1'b1;
        repeat (3) tick();
        check("e_errframe", 32'(ef_cnt - ef0), 32'd1);
        check("e_no_fdone", 32'(fd_cnt - fd0), 32'd0);
        vsync = 1'b0;
        repeat (2) tick();
        pat_frame();
        compare_writes("e");
        check("e_fstart", 32'(fs_cnt - fs0), 32'd2);
        check("e_fdone",  32'(fd_cnt - fd0), 32'd1);
        check("e_frame_cnt", 32'(frame_cnt), 32'd6);
        check("e_busy_cont", 32'(busy), 32'd1);

        // F: reset mid-line 2 clears everything; a fresh arm captures from 0.
        snap();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < H; c++)
                exp_q.push_back(mk(r * H + c, pat_word(r, c)));
        for (int c = 0; c < 3; c++) exp_q.push_back(mk(16 + c, pat_word(2, c)));
        start_frame();
        pat_line(0, H); blank(2);
        pat_line(1, H); blank(2);
        pat_line(2, 3);
        send_byte(8'h53, 1'b1);
        rst = 1'b0;
        tick();
        check_all_zero("f_rst");
        rst = 1'b1;
        cont = 1'b0;
        tick();
        compare_writes("f_partial");
        check("f_no_fdone", 32'(fd_cnt - fd0), 32'd0);
        snap();
        arm_pulse();
        push_full_pat();
        start_frame();
        pat_frame();
        wait_idle("f");
        compare_writes("f");
        check("f_fdone", 32'(fd_cnt - fd0), 32'd1);
        check("f_fd_gap", 32'(fd_gap), 32'd1);
        check("f_frame_cnt", 32'(frame_cnt), 32'd1);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
